// File: rtl/period_meter_pkg.sv
// Shared alarm constants and the period meter FSM state encoding.
// Dividers and meters derive their cycle counts from CLK_HZ / EXP_4HZ.
package period_meter_pkg;

  localparam int CLK_HZ  = 50000000;
  localparam int EXP_4HZ = 12500000;

  typedef enum logic {
    ST_WAIT_FIRST = 1'b0,
    ST_RUN        = 1'b1
  } pm_state_e;

endpackage

// File: rtl/period_meter_if.sv
// Measurement bus: the square wave in, edge/period/lock/stall reports out.
interface period_meter_if #(
  parameter int CNT_W = 32
);

  logic             sig_in;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             stalled;

  modport master (
    output sig_in,
    input  edge_pulse, period, period_vld, locked, stalled
  );

  modport slave (
    input  sig_in,
    output edge_pulse, period, period_vld, locked, stalled
  );

endinterface

// File: rtl/period_meter_sync_rise_det.sv
// Synchroniser chain plus history flop; rise is offered both combinationally
// (for same-cycle consumers) and as a registered one-cycle pulse.
module period_meter_sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_rise_q
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise_q;
  logic              w_rise;

  assign w_rise   = r_sync[STAGES-1] & ~r_hist;
  assign o_rise   = w_rise;
  assign o_rise_q = r_rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_hist   <= 1'b0;
      r_rise_q <= 1'b0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_d};
      r_hist   <= r_sync[STAGES-1];
      r_rise_q <= w_rise;
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures rising-edge to rising-edge distance of a slow input in clk cycles,
// with lock against an expected period and a stall timeout.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int EXP_PERIOD  = EXP_4HZ,
  parameter int TOL         = 1250,
  parameter int TIMEOUT     = CLK_HZ / 2
) (
  input  logic          clk,
  input  logic          rst,
  period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   LP_EXP_X    = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   LP_TOL_X    = (CNT_W+1)'(TOL);

  pm_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_vld;
  logic             r_locked;
  logic             r_stalled;

  logic             w_rise;
  logic             w_rise_q;
  logic [CNT_W:0]   w_cnt_x;
  logic [CNT_W:0]   w_diff;
  logic             w_in_tol;

  period_meter_sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_d      (bus.sig_in),
    .o_rise   (w_rise),
    .o_rise_q (w_rise_q)
  );

  // One extra bit so |cnt - EXP_PERIOD| never wraps.
  assign w_cnt_x  = {1'b0, r_cnt};
  assign w_diff   = (w_cnt_x >= LP_EXP_X) ? (w_cnt_x - LP_EXP_X) : (LP_EXP_X - w_cnt_x);
  assign w_in_tol = (w_diff <= LP_TOL_X);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_WAIT_FIRST;
      r_cnt        <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_locked     <= 1'b0;
      r_stalled    <= 1'b0;
    end else begin
      r_period_vld <= 1'b0;
      case (r_state)
        ST_WAIT_FIRST: begin
          if (w_rise) begin
            r_cnt     <= CNT_W'(1);
            r_stalled <= 1'b0;
            r_state   <= ST_RUN;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          // A rise on the timeout cycle wins over the timeout.
          if (w_rise) begin
            r_period     <= r_cnt;
            r_period_vld <= 1'b1;
            r_locked     <= w_in_tol;
            r_stalled    <= 1'b0;
            r_cnt        <= CNT_W'(1);
          end else if (r_cnt == LP_CNT_LAST) begin
            r_stalled <= 1'b1;
            r_locked  <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT_FIRST;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_WAIT_FIRST;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.edge_pulse = w_rise_q;
  assign bus.period     = r_period;
  assign bus.period_vld = r_period_vld;
  assign bus.locked     = r_locked;
  assign bus.stalled    = r_stalled;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: scoreboard of expected edge pulses and period
// reports derived from the driven waveform, plus table and corner sequences.
module tb_period_meter;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 32;
  localparam int EXP_PERIOD  = 100;
  localparam int TOL         = 2;
  localparam int TIMEOUT     = 250;

  logic clk;
  logic rst;

  period_meter_if #(.CNT_W(CNT_W)) bus ();

  period_meter #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .EXP_PERIOD  (EXP_PERIOD),
    .TOL         (TOL),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: times (cycles since reset release) of expected pulses.
  int  q_pulse[$];
  int  k;
  bit  prev_v;
  bit  run;
  int  last_k;
  bit  m_pulse, m_vld, m_locked, m_stalled;
  longint m_period;

  // Observed DUT history for the hand-written checks.
  int     cur_k;
  int     n_pulse, n_vld;
  int     last_pulse_k;
  longint last_vld_period;
  bit     last_vld_locked;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_vld;
    int exp_period;
    bit exp_locked;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, cur_k, $time);
    end
  endtask

  task automatic cycle(input bit v, input bit r);
    bus.sig_in = v;
    rst        = r;
    @(posedge clk);
    #1;
    cur_k = k;
    if (r) begin
      q_pulse.delete();
      k = 0; prev_v = 0; run = 0;
      m_pulse = 0; m_vld = 0; m_locked = 0; m_stalled = 0; m_period = 0;
    end else begin
      if (v && !prev_v) q_pulse.push_back(k + SYNC_STAGES);
      prev_v  = v;
      m_pulse = (q_pulse.size() > 0) && (q_pulse[0] == k);
      if (m_pulse) void'(q_pulse.pop_front());
      m_vld = 0;
      if (m_pulse) begin
        if (run) begin
          m_period = k - last_k;
          m_vld    = 1;
          m_locked = (m_period >= EXP_PERIOD - TOL) && (m_period <= EXP_PERIOD + TOL);
        end
        m_stalled = 0;
        run       = 1;
        last_k    = k;
      end else if (run && (k - last_k == TIMEOUT - 1)) begin
        m_stalled = 1;
        m_locked  = 0;
        run       = 0;
      end
    end
    chk("edge_pulse", bus.edge_pulse, m_pulse);
    chk("period_vld", bus.period_vld, m_vld);
    chk("period",     bus.period,     m_period);
    chk("locked",     bus.locked,     m_locked);
    chk("stalled",    bus.stalled,    m_stalled);
    if (bus.edge_pulse) begin n_pulse++; last_pulse_k = cur_k; end
    if (bus.period_vld) begin
      n_vld++;
      last_vld_period = bus.period;
      last_vld_locked = bus.locked;
    end
    if (!r) k++;
  endtask

  task automatic wave(input int hi, input int lo);
    repeat (hi) cycle(1'b1, 1'b0);
    repeat (lo) cycle(1'b0, 1'b0);
  endtask

  initial begin
    int v0, p0, stall_k;
    bit seen;

    rst        = 1'b1;
    bus.sig_in = 1'b0;
    k = 0; n_pulse = 0; n_vld = 0; last_pulse_k = 0; stall_k = 0;
    last_vld_period = 0; last_vld_locked = 0;

    tbl[0] = '{hi: 50, lo: 50, reps: 3, exp_vld: 2, exp_period: 100, exp_locked: 1'b1};
    tbl[1] = '{hi: 52, lo: 51, reps: 2, exp_vld: 2, exp_period: 103, exp_locked: 1'b0};
    tbl[2] = '{hi: 49, lo: 49, reps: 2, exp_vld: 2, exp_period: 98,  exp_locked: 1'b1};
    tbl[3] = '{hi: 52, lo: 50, reps: 2, exp_vld: 2, exp_period: 102, exp_locked: 1'b1};
    tbl[4] = '{hi: 50, lo: 47, reps: 2, exp_vld: 2, exp_period: 97,  exp_locked: 1'b0};
    tbl[5] = '{hi: 1,  lo: 1,  reps: 4, exp_vld: 4, exp_period: 2,   exp_locked: 1'b0};

    repeat (3) cycle(1'b0, 1'b1);
    chk("reset_period",  bus.period,     0);
    chk("reset_stalled", bus.stalled,    0);

    // Square waves of fixed period; the trailing lows flush the last pulse.
    for (int i = 0; i < 6; i++) begin
      v0 = n_vld;
      repeat (tbl[i].reps) wave(tbl[i].hi, tbl[i].lo);
      repeat (SYNC_STAGES) cycle(1'b0, 1'b0);
      chk("tbl_vld_count", n_vld - v0,      tbl[i].exp_vld);
      chk("tbl_period",    last_vld_period, tbl[i].exp_period);
      chk("tbl_locked",    last_vld_locked, tbl[i].exp_locked);
    end

    // Input held low: stall must appear TIMEOUT-1 cycles after the last pulse.
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.stalled) begin seen = 1; stall_k = cur_k; end
    end
    chk("stall_seen", bus.stalled, 1);
    chk("stall_dist", stall_k - last_pulse_k, TIMEOUT - 1);
    chk("stall_locked", bus.locked, 0);

    // Next edge clears stall without a report; following edge at distance 249.
    v0 = n_vld;
    wave(5, 244);
    chk("restart_no_vld",  n_vld - v0, 0);
    chk("restart_stalled", bus.stalled, 0);
    repeat (3) cycle(1'b1, 1'b0);
    chk("tmo_edge_vld",     n_vld - v0, 1);
    chk("tmo_edge_period",  last_vld_period, TIMEOUT - 1);
    chk("tmo_edge_stalled", bus.stalled, 0);
    repeat (3) cycle(1'b0, 1'b0);

    // Reset mid-period with the input high.
    wave(50, 50);
    wave(50, 50);
    repeat (20) cycle(1'b1, 1'b0);
    p0 = n_pulse;
    v0 = n_vld;
    cycle(1'b1, 1'b1);
    chk("rst_mid_period", bus.period,     0);
    chk("rst_mid_vld",    bus.period_vld, 0);
    chk("rst_mid_locked", bus.locked,     0);
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b1, 1'b0);
    chk("rst_pulse_count", n_pulse - p0, 1);
    chk("rst_pulse_k",     last_pulse_k, SYNC_STAGES);
    chk("rst_no_vld",      n_vld - v0,   0);
    repeat (10) cycle(1'b0, 1'b0);
    wave(30, 30);
    chk("rst_next_vld",    n_vld - v0,      1);
    chk("rst_next_period", last_vld_period, 16);

    // Random waveforms, occasionally long enough to stall.
    for (int i = 0; i < 60; i++) begin
      int hi, lo;
      hi = $urandom_range(1, 40);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 70);
      wave(hi, lo);
    end
    repeat (SYNC_STAGES + 2) cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
